// File: rtl/full_adder_behavioral.sv
// WIDTH-bit full adder with a live combinational result and a one-cycle registered copy.
// An optional carry-chain mode feeds the registered carry back in, so bit-serial adds work.
module full_adder_behavioral #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             chain_en,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q,
  output logic             overflow_q,
  output logic             out_valid
);

  logic             cin_eff;
  logic [WIDTH:0]   full_sum;
  logic             overflow;
  logic [WIDTH-1:0] sum_d;
  logic             carry_out_d;
  logic             overflow_d;
  logic             out_valid_d;
  logic             out_valid_q;

  // Datapath stays live during reset; in chain mode it then sees the cleared carry.
  always_comb begin
    cin_eff   = chain_en ? carry_out_q : carry_in;
    full_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_eff};
    sum       = full_sum[WIDTH-1:0];
    carry_out = full_sum[WIDTH];
    overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Result registers only capture on valid cycles; the valid flag itself never holds.
  always_comb begin
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d       = sum;
      carry_out_d = carry_out;
      overflow_d  = overflow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_behavioral.sv
// Scoreboard bench for full_adder_behavioral: a 1-bit and an 8-bit instance side by side.
module tb_full_adder_behavioral;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] a1, b1, sum1, sum1_q;
  logic       cin1, chain1, vld1, cout1, cout1_q, ovf1_q, ovld1;
  logic [7:0] a8, b8, sum8, sum8_q;
  logic       cin8, chain8, vld8, cout8, cout8_q, ovf8_q, ovld8;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q1[$];
  exp_t q8[$];
  exp_t last8;

  always #5 clk = ~clk;

  full_adder_behavioral #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .carry_in(cin1), .chain_en(chain1),
    .in_valid(vld1), .sum(sum1), .carry_out(cout1), .sum_q(sum1_q), .carry_out_q(cout1_q),
    .overflow_q(ovf1_q), .out_valid(ovld1)
  );

  full_adder_behavioral #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .carry_in(cin8), .chain_en(chain8),
    .in_valid(vld8), .sum(sum8), .carry_out(cout8), .sum_q(sum8_q), .carry_out_q(cout8_q),
    .overflow_q(ovf8_q), .out_valid(ovld8)
  );

  // Reference arithmetic: unsigned add with carry, signed overflow on the top bit.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                 input int w);
    logic [8:0] s;
    exp_t       e;
    s = {1'b0, a} + {1'b0, b} + {8'b0, c};
    if (w == 1) begin
      e.sum  = {7'b0, s[0]};
      e.cout = s[1];
      e.ovf  = (a[0] == b[0]) && (s[0] != a[0]);
    end else begin
      e.sum  = s[7:0];
      e.cout = s[8];
      e.ovf  = (a[7] == b[7]) && (s[7] != a[7]);
    end
    return e;
  endfunction

  task automatic test_reset();
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; vld1 = 1'b1;
    a8 = 8'hff; b8 = 8'h01; cin8 = 1'b0; vld8 = 1'b1;
    #3;
    n_cmp++;
    if ({sum1_q, cout1_q, ovf1_q, ovld1} !== 4'b0) begin
      n_err++; $display("FAIL reset1_pre got %b want 0000", {sum1_q, cout1_q, ovf1_q, ovld1});
    end
    n_cmp++;
    if ({sum8_q, cout8_q, ovf8_q, ovld8} !== 11'b0) begin
      n_err++; $display("FAIL reset8_pre got %h want 000", {sum8_q, cout8_q, ovf8_q, ovld8});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({sum1_q, cout1_q, ovf1_q, ovld1} !== 4'b0) begin
      n_err++; $display("FAIL reset1_edge got %b want 0000", {sum1_q, cout1_q, ovf1_q, ovld1});
    end
    n_cmp++;
    if ({sum1, cout1} !== 2'b11) begin
      n_err++; $display("FAIL reset1_comb got %b want 11", {sum1, cout1});
    end
    vld1 = 1'b0; vld8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb_sweep();
    logic [7:0] sum_tab  = 8'b1001_0110;
    logic [7:0] cout_tab = 8'b1110_1000;
    chain1 = 1'b0; vld1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = 3'(i);
      #1;
      n_cmp++;
      if ({sum1, cout1} !== {sum_tab[i], cout_tab[i]}) begin
        n_err++;
        $display("FAIL comb_sweep[%0d] sum/cout got %b want %b", i, {sum1, cout1},
                 {sum_tab[i], cout_tab[i]});
      end
    end
  endtask

  task automatic test_registered();
    exp_t e;
    @(posedge clk); #1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; chain1 = 1'b0; vld1 = 1'b1;
    q1.push_back(model({7'b0, a1}, {7'b0, b1}, cin1, 1));
    @(posedge clk); #1;
    vld1 = 1'b0;
    n_cmp++;
    if (ovld1 !== 1'b1 || q1.size() == 0) begin
      n_err++; $display("FAIL reg_valid got %b want 1", ovld1);
    end else begin
      e = q1.pop_front();
      n_cmp++;
      if ({sum1_q, cout1_q, ovf1_q} !== {e.sum[0], e.cout, e.ovf}) begin
        n_err++;
        $display("FAIL reg_result got %b want %b", {sum1_q, cout1_q, ovf1_q},
                 {e.sum[0], e.cout, e.ovf});
      end
    end
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({ovld1, sum1_q, cout1_q} !== 3'b011) begin
      n_err++; $display("FAIL reg_hold got %b want 011", {ovld1, sum1_q, cout1_q});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); #2;
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sum1_q, cout1_q, ovf1_q, ovld1} !== 4'b0) begin
      n_err++; $display("FAIL async_reset got %b want 0000", {sum1_q, cout1_q, ovf1_q, ovld1});
    end
    n_cmp++;
    if ({sum1, cout1} !== 2'b10) begin
      n_err++; $display("FAIL async_comb_a got %b want 10", {sum1, cout1});
    end
    b1 = 1'b1; cin1 = 1'b1; #1;
    n_cmp++;
    if ({sum1, cout1} !== 2'b11) begin
      n_err++; $display("FAIL async_comb_b got %b want 11", {sum1, cout1});
    end
    q1.delete(); q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Serial 3 + 1, LSB first; carry_in is held at 1 during chain cycles and must be ignored.
  task automatic test_chain();
    logic [2:0] abits = 3'b011;
    logic [2:0] bbits = 3'b001;
    logic [2:0] res;
    logic       c;
    exp_t       e;
    c = 1'b0;
    res = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      a1 = abits[k]; b1 = bbits[k];
      chain1 = (k != 0);
      cin1 = (k != 0);
      vld1 = 1'b1;
      e = model({7'b0, abits[k]}, {7'b0, bbits[k]}, c, 1);
      c = e.cout;
      q1.push_back(e);
      @(posedge clk); #1;
      n_cmp++;
      if (ovld1 !== 1'b1 || q1.size() == 0) begin
        n_err++; $display("FAIL chain_valid[%0d] got %b want 1", k, ovld1);
      end else begin
        e = q1.pop_front();
        n_cmp++;
        if ({sum1_q, cout1_q} !== {e.sum[0], e.cout}) begin
          n_err++;
          $display("FAIL chain_bit[%0d] got %b want %b", k, {sum1_q, cout1_q}, {e.sum[0], e.cout});
        end
      end
      res[k] = sum1_q;
    end
    vld1 = 1'b0;
    n_cmp++;
    if ({cout1_q, res} !== 4'b0100) begin
      n_err++; $display("FAIL chain_total got %b want 0100", {cout1_q, res});
    end
    chain1 = 1'b0;
  endtask

  task automatic test_width8();
    logic [7:0] av [3] = '{8'hff, 8'h7f, 8'hff};
    logic [7:0] bv [3] = '{8'h01, 8'h01, 8'hff};
    logic       cv [3] = '{1'b0, 1'b0, 1'b1};
    exp_t       e;
    @(posedge clk); #1;
    chain8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a8 = av[k]; b8 = bv[k]; cin8 = cv[k]; vld8 = 1'b1;
      e = model(av[k], bv[k], cv[k], 8);
      q8.push_back(e);
      #1;
      n_cmp++;
      if ({sum8, cout8} !== {e.sum, e.cout}) begin
        n_err++; $display("FAIL w8_comb[%0d] got %h want %h", k, {sum8, cout8}, {e.sum, e.cout});
      end
      @(posedge clk); #1;
      n_cmp++;
      if (ovld8 !== 1'b1 || q8.size() == 0) begin
        n_err++; $display("FAIL w8_valid[%0d] got %b want 1", k, ovld8);
      end else begin
        e = q8.pop_front();
        last8 = e;
        n_cmp++;
        if ({sum8_q, cout8_q, ovf8_q} !== {e.sum, e.cout, e.ovf}) begin
          n_err++;
          $display("FAIL w8_reg[%0d] got %h want %h", k, {sum8_q, cout8_q, ovf8_q},
                   {e.sum, e.cout, e.ovf});
        end
      end
    end
    vld8 = 1'b0;
    // Registered carry is 1 now, so chaining 0 + 0 must give 1.
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; chain8 = 1'b1;
    #1;
    n_cmp++;
    if ({sum8, cout8} !== 9'h002) begin
      n_err++; $display("FAIL w8_chain_comb got %h want 002", {sum8, cout8});
    end
    chain8 = 1'b0;
  endtask

  task automatic test_hold();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b0; vld8 = 1'b0;
      e = model(a8, b8, 1'b0, 8);
      #1;
      n_cmp++;
      if ({sum8, cout8} !== {e.sum, e.cout}) begin
        n_err++; $display("FAIL hold_comb[%0d] got %h want %h", k, {sum8, cout8}, {e.sum, e.cout});
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({ovld8, sum8_q, cout8_q, ovf8_q} !== {1'b0, last8.sum, last8.cout, last8.ovf}) begin
        n_err++;
        $display("FAIL hold_reg[%0d] got %h want %h", k, {ovld8, sum8_q, cout8_q, ovf8_q},
                 {1'b0, last8.sum, last8.cout, last8.ovf});
      end
    end
    n_cmp++;
    if (q8.size() != 0 || q1.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain got %0d want 0", q8.size() + q1.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0; chain1 = 1'b0; vld1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; chain8 = 1'b0; vld8 = 1'b0;
    last8 = '0;
    test_reset();
    test_comb_sweep();
    test_registered();
    test_async_reset();
    test_chain();
    test_width8();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
